// File: rtl/q_meas_avg.sv
// q_meas_avg: after each trigger, waits out a settling window, then averages ADC samples into q_measured.
// Define Q_MEAS_MINMAX_REJECT_EN to collect 2**LOG2_N+2 samples and drop one minimum and one maximum.
module q_meas_avg #(
  parameter int BUS_WIDTH     = 10,
  parameter int LOG2_N        = 3,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] adc_sample,
  input  logic                 adc_valid,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 q_valid,
  output logic                 busy
);

`ifdef Q_MEAS_MINMAX_REJECT_EN
  localparam int NSAMP = (2 ** LOG2_N) + 2;
`else
  localparam int NSAMP = 2 ** LOG2_N;
`endif
  localparam int AW = BUS_WIDTH + LOG2_N + 1;
  localparam int CW = $clog2(NSAMP + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SAMP_LAST   = CW'(NSAMP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_TRIM, S_DONE} state_t;

  localparam state_t START_ST = (SETTLE_CYCLES == 0) ? S_ACCUM : S_SETTLE;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] i_ref_q;
  logic [SW-1:0]        settle_q, settle_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [BUS_WIDTH-1:0] q_meas_q, q_meas_d;
  logic                 q_valid_q, q_valid_d;
  logic                 trig;
  logic                 restart;
`ifdef Q_MEAS_MINMAX_REJECT_EN
  logic [BUS_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic                 pend_q, pend_d;
`endif

  always_comb begin
    trig      = start || (i_ref != i_ref_q);
    state_d   = state_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_meas_d  = q_meas_q;
    q_valid_d = 1'b0;
    restart   = 1'b0;
`ifdef Q_MEAS_MINMAX_REJECT_EN
    min_d     = min_q;
    max_d     = max_q;
    pend_d    = pend_q;
`endif
    case (state_q)
      S_IDLE: restart = trig;
      S_SETTLE: begin
        if (trig)                          restart  = 1'b1;
        else if (settle_q == SETTLE_LAST)  state_d  = S_ACCUM;
        else                               settle_d = settle_q + SW'(1);
      end
      S_ACCUM: begin
        if (trig) begin
          restart = 1'b1;
        end else if (adc_valid) begin
          acc_d = acc_q + AW'(adc_sample);
          cnt_d = cnt_q + CW'(1);
`ifdef Q_MEAS_MINMAX_REJECT_EN
          if (cnt_q == '0 || adc_sample < min_q) min_d = adc_sample;
          if (cnt_q == '0 || adc_sample > max_q) max_d = adc_sample;
          if (cnt_q == SAMP_LAST) state_d = S_TRIM;
`else
          if (cnt_q == SAMP_LAST) state_d = S_DONE;
`endif
        end
      end
`ifdef Q_MEAS_MINMAX_REJECT_EN
      // Trim stage is part of the publish sequence: a trigger here is remembered, not an abort.
      S_TRIM: begin
        acc_d   = acc_q - AW'(min_q) - AW'(max_q);
        pend_d  = trig;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        q_meas_d  = acc_q[LOG2_N +: BUS_WIDTH];
        q_valid_d = 1'b1;
`ifdef Q_MEAS_MINMAX_REJECT_EN
        restart   = trig || pend_q;
`else
        restart   = trig;
`endif
        if (!restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (restart) begin
      state_d  = START_ST;
      settle_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
`ifdef Q_MEAS_MINMAX_REJECT_EN
      pend_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    i_ref_q <= i_ref;
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_meas_q  <= '0;
      q_valid_q <= 1'b0;
`ifdef Q_MEAS_MINMAX_REJECT_EN
      min_q     <= '0;
      max_q     <= '0;
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_meas_q  <= q_meas_d;
      q_valid_q <= q_valid_d;
`ifdef Q_MEAS_MINMAX_REJECT_EN
      min_q     <= min_d;
      max_q     <= max_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign q_measured = q_meas_q;
  assign q_valid    = q_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_q_meas_avg.sv
// Directed bench for q_meas_avg: expected results are queued at trigger time and matched on q_valid.
module tb_q_meas_avg;
  localparam int BW     = 10;
  localparam int L2N    = 3;
  localparam int SETTLE = 16;
`ifdef Q_MEAS_MINMAX_REJECT_EN
  localparam int NS    = 10;
  localparam int EXTRA = 1;
`else
  localparam int NS    = 8;
  localparam int EXTRA = 0;
`endif
  localparam int LAT = SETTLE + NS + 1 + EXTRA;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] i_ref;
  logic          start;
  logic [BW-1:0] adc_sample;
  logic          adc_valid;
  logic [BW-1:0] q_measured;
  logic          q_valid;
  logic          busy;

  q_meas_avg #(
    .BUS_WIDTH    (BW),
    .LOG2_N       (L2N),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_ref     (i_ref),
    .start     (start),
    .adc_sample(adc_sample),
    .adc_valid (adc_valid),
    .q_measured(q_measured),
    .q_valid   (q_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    vec  = 0;
  int    miss = 0;
  string phase = "init";
  int    trig;
  int    t2;
  int    e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s/%s: got %0d, want %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) step();
    chk("results_outstanding", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  function automatic int ramp_avg(input int base);
    int s = 0;
    for (int i = 0; i < NS; i++) s += base + i;
`ifdef Q_MEAS_MINMAX_REJECT_EN
    s = s - base - (base + NS - 1);
`endif
    return s >> L2N;
  endfunction

  // Every q_valid pulse must match the oldest queued expectation in value and edge.
  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("q_valid_unexpected", 32'(q_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("q_measured", 32'(q_measured), 32'(mon_e.val));
        chk("q_valid_edge", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    i_ref      = 10'd1023;
    start      = 1'b0;
    adc_sample = 10'd5;
    adc_valid  = 1'b1;
    repeat (3) step();

    phase = "reset";
    chk("busy", 32'(busy), 32'd0);
    chk("q_measured", 32'(q_measured), 32'd0);
    chk("q_valid", 32'(q_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 25 == 24) begin
        chk("busy_idle", 32'(busy), 32'd0);
        chk("q_measured_idle", 32'(q_measured), 32'd0);
      end
    end

    phase = "iref_change";
    i_ref      = 10'd511;
    adc_sample = 10'd110;
    trig = cyc + 1;
    sb.push_back('{val: 110, due: trig + LAT});
    step();
    chk("busy_settle", 32'(busy), 32'd1);
    drain(LAT + 5);
    chk("q_valid_after", 32'(q_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);

    phase = "start_ramp";
    start = 1'b1;
    adc_sample = 10'd999;
    trig = cyc + 1;
    sb.push_back('{val: ramp_avg(100), due: trig + LAT});
    for (int i = 0; i < LAT + 5 && sb.size() > 0; i++) begin
      step();
      start = 1'b0;
      e = cyc + 1 - (trig + SETTLE + 1);
      adc_sample = (e >= 0 && e < NS) ? BW'(100 + e) : 10'd999;
    end
    drain(0);

    phase = "retrigger_accum";
    i_ref      = 10'd300;
    adc_sample = 10'd200;
    trig = cyc + 1;
    for (int i = 0; i < SETTLE + 4; i++) step();
    t2 = cyc + 1;
    i_ref      = 10'd400;
    adc_sample = 10'd60;
    sb.push_back('{val: 60, due: t2 + LAT});
    drain(LAT + 5);

    phase = "valid_toggle";
    start      = 1'b1;
    adc_sample = 10'd40;
    trig = cyc + 1;
    sb.push_back('{val: 40, due: trig + SETTLE + 2 * NS + 1 + EXTRA});
    for (int i = 0; i < 3 * LAT && sb.size() > 0; i++) begin
      adc_valid = ((cyc + 1 - trig) % 2 == 0);
      step();
      start = 1'b0;
    end
    adc_valid = 1'b1;
    drain(0);

    phase = "trigger_in_done";
    start      = 1'b1;
    adc_sample = 10'd77;
    trig = cyc + 1;
    sb.push_back('{val: 77, due: trig + LAT});
    sb.push_back('{val: 33, due: trig + 2 * LAT});
    step();
    start = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    start      = 1'b1;
    adc_sample = 10'd33;
    step();
    start = 1'b0;
    drain(2 * LAT);
    chk("busy_after", 32'(busy), 32'd0);

    phase = "reset_mid_accum";
    start      = 1'b1;
    adc_sample = 10'd90;
    step();
    start = 1'b0;
    for (int i = 0; i < SETTLE + 2; i++) step();
    rst = 1'b1;
    step();
    chk("busy", 32'(busy), 32'd0);
    chk("q_measured", 32'(q_measured), 32'd0);
    chk("q_valid", 32'(q_valid), 32'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("busy_quiet", 32'(busy), 32'd0);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
